// File: rtl/dmux_stream.sv
// Registered 1-to-WAYS stream demultiplexer with per-transfer select and broadcast.
// Each channel owns a one-entry output register; out-of-range selects are accepted and counted.
module dmux_stream #(
  parameter int WIDTH = 8,
  parameter int WAYS  = 4,
  parameter int SEL_W = $clog2(WAYS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH-1:0]        in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_bcast,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WAYS*WIDTH-1:0]   out_data,
  output logic [WAYS-1:0]         out_valid,
  input  logic [WAYS-1:0]         out_ready,
  output logic [7:0]              drop_cnt
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // Producer side: in_valid may not depend on in_ready; payload is don't-care while in_valid=0.
  // Consumer side: out_data[k] holds steady while out_valid[k]=1 and out_ready[k]=0.

  localparam logic [SEL_W:0] WAYS_L = (SEL_W+1)'(WAYS);

  logic [WAYS*WIDTH-1:0] data_q, data_d;
  logic [WAYS-1:0]       valid_q, valid_d;
  logic [7:0]            drop_q, drop_d;

  logic [WAYS-1:0]       free;
  logic                  sel_free;
  logic                  in_range;
  logic                  accept;

  // A channel is free when empty or being drained this cycle, allowing same-cycle refill.
  always_comb begin
    free     = ~valid_q | out_ready;
    sel_free = 1'b0;
    for (int k = 0; k < WAYS; k++) begin
      if (in_sel == SEL_W'(k)) sel_free = free[k];
    end
    in_range = ({1'b0, in_sel} < WAYS_L);
    if (!rst_n)          in_ready = 1'b0;
    else if (in_bcast)   in_ready = &free;
    else if (!in_range)  in_ready = 1'b1;
    else                 in_ready = sel_free;
  end

  assign accept = in_valid & in_ready;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    drop_d  = drop_q;
    for (int k = 0; k < WAYS; k++) begin
      if (accept && (in_bcast || (in_range && in_sel == SEL_W'(k)))) begin
        data_d[k*WIDTH +: WIDTH] = in_data;
        valid_d[k]               = 1'b1;
      end else if (out_ready[k]) begin
        valid_d[k] = 1'b0;
      end
    end
    if (accept && !in_bcast && !in_range && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= '0;
      drop_q  <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_dmux_stream.sv
// Directed and model-checked bench for dmux_stream (WAYS=4 main instance, WAYS=3 drop instance).
module tb_dmux_stream;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic        in_bcast;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [7:0]  drop_cnt;

  logic [1:0]  d3_sel;
  logic        d3_valid;
  logic        d3_in_ready;
  logic [23:0] d3_out_data;
  logic [2:0]  d3_out_valid;
  logic [7:0]  d3_drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  dmux_stream #(.WIDTH(8), .WAYS(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .drop_cnt(drop_cnt)
  );

  dmux_stream #(.WIDTH(8), .WAYS(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(d3_sel), .in_bcast(1'b0),
    .in_valid(d3_valid), .in_ready(d3_in_ready), .out_data(d3_out_data),
    .out_valid(d3_out_valid), .out_ready(3'b111), .drop_cnt(d3_drop_cnt)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] sel, input logic [7:0] data, input logic bcast);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = data;
    in_bcast = bcast;
  endtask

  // Bench-side model for the random phase
  logic [3:0]  mdl_v;
  logic [31:0] mdl_d;
  logic [3:0]  mdl_free;
  logic        exp_ready;
  logic [31:0] mask;
  int          bad_valid;

  initial begin
    rst_n = 1'b0; in_data = '0; in_sel = '0; in_bcast = 1'b0; in_valid = 1'b0;
    out_ready = 4'hF; d3_sel = '0; d3_valid = 1'b0;
    #1;
    check("reset_in_ready", 32'(in_ready), 32'h0);
    check("reset_out_valid", 32'(out_valid), 32'h0);
    check("reset_out_data", out_data, 32'h0);
    check("reset_drop_cnt", 32'(drop_cnt), 32'h0);
    #21 rst_n = 1'b1;
    step();

    // Drop: WAYS=3 instance, sel=3 x300
    d3_valid = 1'b1; d3_sel = 2'd3; in_data = 8'h99;
    #1;
    check("drop_in_ready", 32'(d3_in_ready), 32'h1);
    bad_valid = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (d3_out_valid != 3'b000) bad_valid++;
      if (i == 9) check("drop_cnt_10", 32'(d3_drop_cnt), 32'd10);
    end
    check("drop_no_valid", 32'(bad_valid), 32'h0);
    check("drop_saturate", 32'(d3_drop_cnt), 32'd255);
    d3_sel = 2'd2; in_data = 8'h5A;
    step();
    d3_valid = 1'b0;
    #1;
    check("d3_inrange_valid", 32'(d3_out_valid), 32'b100);
    check("d3_inrange_data", 32'(d3_out_data[23:16]), 32'h5A);
    check("d3_drop_hold", 32'(d3_drop_cnt), 32'd255);
    step();

    // Unicast sweep
    out_ready = 4'hF;
    for (int i = 0; i < 4; i++) begin
      send(2'(i), 8'hA0 + 8'(i), 1'b0);
      #1;
      check("sweep_in_ready", 32'(in_ready), 32'h1);
      if (i == 0) check("sweep_idle", 32'(out_valid), 32'h0);
      else begin
        check("sweep_valid", 32'(out_valid), 32'(4'b0001 << (i - 1)));
        check("sweep_data", 32'(out_data[(i-1)*8 +: 8]), 32'(8'hA0 + 8'(i - 1)));
      end
      step();
    end
    in_valid = 1'b0;
    #1;
    check("sweep_last_valid", 32'(out_valid), 32'b1000);
    check("sweep_last_data", 32'(out_data[31:24]), 32'hA3);
    step();
    check("sweep_drained", 32'(out_valid), 32'h0);

    // Backpressure on channel 2
    out_ready = 4'b1011;
    send(2'd2, 8'h55, 1'b0);
    #1 check("bp_first_ready", 32'(in_ready), 32'h1);
    step();
    send(2'd2, 8'h66, 1'b0);
    #1;
    check("bp_second_blocked", 32'(in_ready), 32'h0);
    check("bp_ch2_data", 32'(out_data[23:16]), 32'h55);
    step();
    check("bp_ch2_hold", 32'(out_data[23:16]), 32'h55);
    check("bp_ch2_valid", 32'(out_valid), 32'b0100);
    send(2'd1, 8'h77, 1'b0);
    #1 check("bp_ch1_ready", 32'(in_ready), 32'h1);
    step();
    check("bp_ch1_valid", 32'(out_valid), 32'b0110);
    check("bp_ch1_data", 32'(out_data[15:8]), 32'h77);
    check("bp_ch2_still", 32'(out_data[23:16]), 32'h55);
    send(2'd2, 8'h66, 1'b0);
    #1 check("bp_still_blocked", 32'(in_ready), 32'h0);
    out_ready = 4'hF;
    #1 check("bp_release_ready", 32'(in_ready), 32'h1);
    step();
    in_valid = 1'b0;
    #1;
    check("bp_release_valid", 32'(out_valid), 32'b0100);
    check("bp_release_data", 32'(out_data[23:16]), 32'h66);
    step();
    check("bp_drained", 32'(out_valid), 32'h0);

    // Broadcast blocked by a full channel 3
    out_ready = 4'b0111;
    send(2'd3, 8'h33, 1'b0);
    step();
    send(2'd1, 8'hC3, 1'b1);
    #1 check("bc_blocked", 32'(in_ready), 32'h0);
    step();
    check("bc_no_load_valid", 32'(out_valid), 32'b1000);
    check("bc_no_load_data", out_data, {8'h33, 8'h66, 8'h77, 8'hA0});
    out_ready = 4'hF;
    #1 check("bc_ready", 32'(in_ready), 32'h1);
    step();
    in_valid = 1'b0; in_bcast = 1'b0;
    #1;
    check("bc_all_valid", 32'(out_valid), 32'hF);
    check("bc_all_data", out_data, {4{8'hC3}});
    step();
    check("bc_drained", 32'(out_valid), 32'h0);

    // Asynchronous reset mid-cycle with out_valid=1010 and drop_cnt nonzero
    out_ready = 4'b0101;
    send(2'd1, 8'h11, 1'b0);
    step();
    send(2'd3, 8'h33, 1'b0);
    step();
    in_valid = 1'b0;
    #1 check("pre_reset_valid", 32'(out_valid), 32'b1010);
    in_valid = 1'b1; in_sel = 2'd0; out_ready = 4'hF;
    #1 rst_n = 1'b0;
    #1;
    check("async_out_valid", 32'(out_valid), 32'h0);
    check("async_out_data", out_data, 32'h0);
    check("async_drop_cnt", 32'(d3_drop_cnt), 32'h0);
    check("async_in_ready", 32'(in_ready), 32'h0);
    @(posedge clk); #1;
    check("reset_hold_valid", 32'(out_valid), 32'h0);
    check("reset_hold_ready", 32'(in_ready), 32'h0);
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    step();
    check("post_reset_valid", 32'(out_valid), 32'h0);

    // Random traffic against the bench model
    mdl_v = '0;
    mdl_d = '0;
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_bcast  = ($urandom_range(0, 7) == 0);
      in_sel    = 2'($urandom_range(0, 3));
      in_data   = 8'($urandom_range(0, 255));
      out_ready = 4'($urandom_range(0, 15));
      #1;
      mdl_free = ~mdl_v | out_ready;
      exp_ready = in_bcast ? (&mdl_free) : mdl_free[in_sel];
      mask = '0;
      for (int k = 0; k < 4; k++) if (mdl_v[k]) mask[k*8 +: 8] = 8'hFF;
      check("rnd_in_ready", 32'(in_ready), 32'(exp_ready));
      check("rnd_out_valid", 32'(out_valid), 32'(mdl_v));
      check("rnd_out_data", out_data & mask, mdl_d & mask);
      for (int k = 0; k < 4; k++) begin
        if (in_valid && exp_ready && (in_bcast || in_sel == 2'(k))) begin
          mdl_v[k] = 1'b1;
          mdl_d[k*8 +: 8] = in_data;
        end else if (out_ready[k]) begin
          mdl_v[k] = 1'b0;
        end
      end
      step();
    end
    in_valid = 1'b0;
    #1 check("rnd_final_valid", 32'(out_valid), 32'(mdl_v));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
